edge_run_encoder: RTL and testbench
===================================

Name: edge_run_encoder

Overview:
- Sits directly downstream of the edge detection chain (smoothing, derivative, threshold) and consumes its 8-bit Edges stream, one sample per enb cycle.
- Converts the per-sample edge flags into run records {start index, run length}, one per contiguous run of edge samples.
- Buffers records in a small first-word-fall-through (FWFT) FIFO with a valid/ready read port for the host or logging stage.

Parameters:
- IDX_W, 16, width of the sample index counter and of out_start.
- LEN_W, 8, width of the run length field; maximum run length is 2^LEN_W-1.
- DEPTH, 8, FIFO depth in records; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  sample strobe; Edges is sampled only when enb=1.
- frame_start  in  1  marks the sample accepted this cycle as index 0; ignored when enb=0.
- Edges  in  8  edge flag from the threshold stage; any nonzero value is an edge.
- out_ready  in  1  consumer accepts the head record.
- out_valid  out  1  FIFO is non-empty.
- out_start  out  IDX_W  index of the first sample of the head run.
- out_len  out  LEN_W  length of the head run, always 1..2^LEN_W-1.
- fifo_count  out  log2(DEPTH)+1  number of records held.
- overflow  out  1  sticky flag: at least one record was dropped.

Behaviour:
- Reset: all outputs 0, index=0, FSM=IDLE, FIFO empty, overflow=0. Reset also aborts any open run without emitting it.
- Accepted sample: enb=1. When enb=0 the block holds all state, except that the FIFO read side still operates.
- Index of an accepted sample:
  - frame_start=1: the sample's index is 0 and the counter becomes 1.
  - frame_start=0: the sample's index is the current count, and the count increments modulo 2^IDX_W (silent wrap).
- Edge: e = (Edges != 0).
- FSM IDLE:
  - accepted e=1: run_start=idx, run_len=1, go to RUN.
  - accepted e=0: stay in IDLE.
- FSM RUN, frame_start=0:
  - e=1 and run_len < max: run_len++.
  - e=1 and run_len = max: emit {run_start, max}, then run_start=idx, run_len=1, stay in RUN (a long run splits into chunks).
  - e=0: emit {run_start, run_len}, go to IDLE.
- FSM RUN, frame_start=1: emit the open run unchanged, then handle the sample as in IDLE with idx=0.
- Emit timing: exactly one FIFO write per accepted sample at most. The record is written on the clock edge that accepts the terminating sample; out_valid can rise on the next cycle, giving 1-cycle latency from the terminating sample to visibility.
- Runs open at a frame boundary are not closed by the index wrap; only e=0, saturation, or frame_start closes them.
- FIFO read port:
  - out_start/out_len show the head record combinationally from registered storage.
  - Pop occurs on out_valid & out_ready.
  - out_ready while empty has no effect.
- FIFO write port:
  - Write while full and no pop in the same cycle: the record is dropped, overflow=1 (held until reset), FIFO contents unchanged.
  - Write while full with a pop in the same cycle: the write is accepted and fifo_count stays at DEPTH.
  - Simultaneous push and pop at any fill level leaves fifo_count unchanged.
- Output stability: while out_valid=1 and out_ready=0, out_start/out_len hold stable.

Test Plan:
- Reset then Edges=0,0,5,1,1,0 with enb=1 every cycle and out_ready=1 -> one record start=2, len=3; out_valid is high for exactly 1 cycle, the cycle after the sample at index 5 is accepted.
- Same sequence with enb deasserted for 3 cycles mid-run -> identical record; run_len is unaffected by gaps.
- 300 consecutive nonzero samples from index 0, then a 0, with LEN_W=8 -> records {0,255} then {255,45}.
- Run open from index 10 for 4 samples, then frame_start=1 with Edges=1 -> records {10,4} emitted; new run starts at 0; next 0 sample emits {0,1}.
- out_ready=0, 9 isolated single-sample edges at even indices 0..16, DEPTH=8 -> fifo_count=8, overflow=1, head={0,1}; drain -> records at indices 0..14, index 16 lost.
- FIFO full with out_ready=1 and an edge record emitted in the same cycle -> fifo_count stays 8, overflow stays 0, new record appears last; then assert reset mid-run -> all outputs 0 and the open run is discarded.

Source files
------------

// File: rtl/edge_run_encoder.sv
// Turns a per-sample edge flag stream into {start index, run length} records
// and queues them in a small first-word-fall-through FIFO with a valid/ready read port.
module edge_run_encoder #(
    parameter int IDX_W = 16,
    parameter int LEN_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enb,
    input  logic                       frame_start,
    input  logic [7:0]                 Edges,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_start,
    output logic [LEN_W-1:0]           out_len,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Run tracker state
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   run_start_q, run_start_d;
    logic [LEN_W-1:0]   run_len_q, run_len_d;
    logic [IDX_W-1:0]   sample_idx;
    logic               edge_hit;
    logic               push;
    logic [IDX_W-1:0]   push_start;
    logic [LEN_W-1:0]   push_len;

    // FIFO state
    logic [IDX_W-1:0]   mem_start [DEPTH];
    logic [LEN_W-1:0]   mem_len   [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               pop;
    logic               full;
    logic               wr_en;

    assign sample_idx = frame_start ? '0 : idx_q;
    assign edge_hit   = |Edges;

    // A record always reports the run as it stood before this sample, so the
    // emitted fields are the current registers, never the next-state values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_start_d = run_start_q;
        run_len_d   = run_len_q;
        push        = 1'b0;
        push_start  = run_start_q;
        push_len    = run_len_q;
        if (enb) begin
            idx_d = sample_idx + 1'b1;
            if (state_q == RUN && (frame_start || !edge_hit || run_len_q == LEN_MAX)) begin
                push = 1'b1;
            end
            if (state_q == IDLE || frame_start) begin
                if (edge_hit) begin
                    run_start_d = sample_idx;
                    run_len_d   = LEN_ONE;
                    state_d     = RUN;
                end else begin
                    state_d     = IDLE;
                end
            end else if (!edge_hit) begin
                state_d = IDLE;
            end else if (run_len_q == LEN_MAX) begin
                run_start_d = sample_idx;
                run_len_d   = LEN_ONE;
            end else begin
                run_len_d = run_len_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            run_start_q <= '0;
            run_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_start_q <= run_start_d;
            run_len_q   <= run_len_d;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write then.
    assign pop   = out_valid & out_ready;
    assign full  = (count_q == CNT_FULL);
    assign wr_en = push & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_start[wr_ptr_q] <= push_start;
            mem_len[wr_ptr_q]   <= push_len;
        end
    end

    // Storage is not reset, so the head fields are forced to zero while empty.
    assign out_valid  = (count_q != '0);
    assign out_start  = out_valid ? mem_start[rd_ptr_q] : '0;
    assign out_len    = out_valid ? mem_len[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_run_encoder.sv
// Directed bench for edge_run_encoder: a vector table for the basic run cases,
// plus hand-written sequences for saturation, frame restart, FIFO full and reset.
module tb_edge_run_encoder;

  logic        clk;
  logic        reset;
  logic        enb;
  logic        frame_start;
  logic [7:0]  edges;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_start;
  logic [7:0]  out_len;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic        fs;
    logic [7:0]  e;
    logic        rdy;
    logic        chk;
    logic        v;
    logic [15:0] st;
    logic [7:0]  ln;
    logic [3:0]  cnt;
    logic        ov;
  } vec_t;

  vec_t vt[$];

  edge_run_encoder #(.IDX_W(16), .LEN_W(8), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .frame_start (frame_start),
    .Edges       (edges),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_start   (out_start),
    .out_len     (out_len),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset = 1'b1;
    enb = 1'b0;
    frame_start = 1'b0;
    edges = 8'd0;
    out_ready = 1'b0;
  end

  // driver tasks: inputs change on the falling edge, outputs sampled 1 time unit later
  task automatic drive(input logic r, input logic en, input logic fs, input logic [7:0] e,
                       input logic rdy);
    @(negedge clk);
    reset = r;
    enb = en;
    frame_start = fs;
    edges = e;
    out_ready = rdy;
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [15:0] st,
                           input logic [7:0] ln, input logic [3:0] cnt, input logic ov);
    cmp({name, ".out_valid"}, 32'(out_valid), 32'(v));
    cmp({name, ".out_start"}, 32'(out_start), 32'(st));
    cmp({name, ".out_len"}, 32'(out_len), 32'(ln));
    cmp({name, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
    cmp({name, ".overflow"}, 32'(overflow), 32'(ov));
  endtask

  task automatic do_reset(input string name);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    check_out(name, 1'b0, 16'd0, 8'd0, 4'd0, 1'b0);
  endtask

  // scoreboard drain: pop every expected record in order, then expect empty
  task automatic drain(input string name, input logic ov);
    logic [23:0] exp_rec;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      exp_rec = exp_q.pop_front();
      drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      cmp($sformatf("%s.rec%0d.valid", name, n), 32'(out_valid), 32'd1);
      cmp($sformatf("%s.rec%0d.start", name, n), 32'(out_start), 32'(exp_rec[23:8]));
      cmp($sformatf("%s.rec%0d.len", name, n), 32'(out_len), 32'(exp_rec[7:0]));
      n++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out({name, ".empty"}, 1'b0, 16'd0, 8'd0, 4'd0, ov);
  endtask

  task automatic add_vec(input logic rst, input logic en, input logic fs, input logic [7:0] e,
                         input logic rdy, input logic chk, input logic v, input logic [15:0] st,
                         input logic [7:0] ln, input logic [3:0] cnt, input logic ov);
    vec_t t;
    t.rst = rst; t.en = en; t.fs = fs; t.e = e; t.rdy = rdy; t.chk = chk;
    t.v = v; t.st = st; t.ln = ln; t.cnt = cnt; t.ov = ov;
    vt.push_back(t);
  endtask

  initial begin
    // Basic run: Edges 0,0,5,1,1,0 -> {2,3}, visible one cycle after index 5
    add_vec(1, 0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd5, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd1, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd1, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 1, 1, 1, 2, 3, 1, 0);
    add_vec(0, 1, 0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    // Same run with a 3-cycle enb gap (inputs during the gap are ignored)
    add_vec(1, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd5, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd1, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'd3, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd1, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 8'd0, 0, 1, 1, 2, 3, 1, 0);
    add_vec(0, 0, 0, 8'd0, 0, 1, 1, 2, 3, 1, 0);
    add_vec(0, 0, 0, 8'd0, 1, 1, 1, 2, 3, 1, 0);
    add_vec(0, 0, 0, 8'd0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].fs, vt[i].e, vt[i].rdy);
      if (vt[i].chk)
        check_out($sformatf("vec%0d", i), vt[i].v, vt[i].st, vt[i].ln, vt[i].cnt, vt[i].ov);
    end

    // 300-sample run splits at the 255 length limit
    do_reset("sat.reset");
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
      if (i == 255) check_out("sat.none_yet", 1'b0, 16'd0, 8'd0, 4'd0, 1'b0);
      if (i == 256) check_out("sat.first_chunk", 1'b1, 16'd0, 8'd255, 4'd1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out("sat.both", 1'b1, 16'd0, 8'd255, 4'd2, 1'b0);
    exp_q.push_back({16'd0, 8'd255});
    exp_q.push_back({16'd255, 8'd45});
    drain("sat", 1'b0);

    // Frame restart closes the open run and starts a new one at index 0
    do_reset("frame.reset");
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'd7, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check_out("frame.first", 1'b1, 16'd10, 8'd4, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out("frame.both", 1'b1, 16'd10, 8'd4, 4'd2, 1'b0);
    exp_q.push_back({16'd10, 8'd4});
    exp_q.push_back({16'd0, 8'd1});
    drain("frame", 1'b0);

    // Overflow: 9 isolated edges into an 8-deep FIFO, the last is dropped
    do_reset("ovf.reset");
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 8'd1 : 8'd0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out("ovf.full", 1'b1, 16'd0, 8'd1, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back({16'(2 * i), 8'd1});
    drain("ovf", 1'b1);

    // Full FIFO with a pop in the same cycle as a write: write accepted
    do_reset("fullpop.reset");
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 8'd2 : 8'd0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd9, 1'b0);
    check_out("fullpop.full", 1'b1, 16'd0, 8'd1, 4'd8, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out("fullpop.after", 1'b1, 16'd2, 8'd1, 4'd8, 1'b0);
    for (int i = 1; i < 8; i++) exp_q.push_back({16'(2 * i), 8'd1});
    exp_q.push_back({16'd16, 8'd1});
    drain("fullpop", 1'b0);

    // Reset mid-run discards the open run and restarts the index
    drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check_out("midrst.zero", 1'b0, 16'd0, 8'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    check_out("midrst.discarded", 1'b0, 16'd0, 8'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check_out("midrst.newrun", 1'b1, 16'd1, 8'd1, 4'd1, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
